pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline sequencing controller for the RV32IM core. It drives the write-enable, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three hazard types:
- load-use hazards, by a one-cycle stall;
- taken branches and jumps, by a flush;
- multi-cycle MUL/DIV operations in EX, by a full front-end freeze with a watchdog.

It is a small Mealy FSM plus counters and sits alongside the hazard/forwarding logic in the ID/EX region.

## Interface
Parameters:
- MD_TIMEOUT, 40, maximum MD_WAIT cycles before the watchdog forces release.

Ports:
- Clocking: one clock; reset is synchronous and active-low.
  - CLK  in  1  clock; all state updates on posedge.
  - RESET  in  1  synchronous active-low reset, sampled on posedge CLK.
- Load-use detection inputs:
  - ID_RS1  in  5  rs1 of the instruction in ID.
  - ID_RS2  in  5  rs2 of the instruction in ID.
  - ID_USES_RS1  in  1  ID instruction reads rs1.
  - ID_USES_RS2  in  1  ID instruction reads rs2.
  - ID_EX_MEM_READ  in  1  instruction in EX is a load.
  - ID_EX_RD  in  5  rd of the instruction in EX.
- EX-stage event inputs:
  - BRANCH_TAKEN  in  1  EX resolved a taken branch or jump.
  - MULDIV_START  in  1  multi-cycle MUL/DIV entered EX this cycle.
  - MULDIV_DONE  in  1  MUL/DIV unit result valid this cycle.
- Pipeline control outputs:
  - PC_WRITE_EN  out  1  PC register update enable.
  - IF_ID_WRITE_EN  out  1  IF/ID capture enable.
  - IF_ID_FLUSH  out  1  IF/ID loads NOP (0x00000013) and PC_PLUS_4 = 0.
  - ID_EX_WRITE_EN  out  1  ID/EX capture enable.
  - ID_EX_BUBBLE  out  1  ID/EX loads all-zero control (bubble).
  - EX_MEM_BUBBLE  out  1  EX/MEM loads bubble.
- Status outputs:
  - STALL_COUNT  out  32  cycles spent in any stall, saturating at 0xFFFFFFFF.
  - MD_TIMEOUT_ERR  out  1  sticky watchdog flag.

## Operation
- States:
  - RUN: normal operation.
  - MD_WAIT: MUL/DIV in progress.
  - Encoding: 1-bit.
- Reset (RESET=0 at posedge):
  - State, counters and flags: state←RUN, md_cnt←0, STALL_COUNT←0, MD_TIMEOUT_ERR←0.
  - Outputs forced while RESET=0: PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_WRITE_EN=0, IF_ID_FLUSH=1, ID_EX_BUBBLE=1, EX_MEM_BUBBLE=1.
  - This applies mid-MD_WAIT too: no wait is resumed after reset.
- Load-use condition lu:
  - lu = ID_EX_MEM_READ & (ID_EX_RD≠0) & ((ID_USES_RS1 & ID_RS1==ID_EX_RD) | (ID_USES_RS2 & ID_RS2==ID_EX_RD)).
- RUN, default outputs: all write enables = 1, all flush/bubble = 0.
- RUN, inputs resolved in strict priority order:
  1. BRANCH_TAKEN: IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_WRITE_EN=1. lu and MULDIV_START are ignored.
  2. MULDIV_START: PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_WRITE_EN=0, EX_MEM_BUBBLE=1. Next state MD_WAIT, md_cnt←1.
  3. lu: PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_BUBBLE=1. State stays RUN.
- MD_WAIT:
  - MULDIV_DONE=1: default (advance) outputs this cycle; next state RUN.
  - Else if md_cnt==MD_TIMEOUT: advance outputs; MD_TIMEOUT_ERR←1; next state RUN.
  - Else: freeze outputs as in RUN case 2; md_cnt←md_cnt+1.
  - BRANCH_TAKEN and lu are ignored in MD_WAIT, because EX holds the MUL/DIV.
  - lu is re-evaluated in RUN after release.
- STALL_COUNT: +1 on every cycle with PC_WRITE_EN=0 and RESET=1; saturates at 0xFFFFFFFF.
- md_cnt width: $clog2(MD_TIMEOUT+1).
- MD_TIMEOUT_ERR clears only on reset.

## Timing
- Control outputs are combinational from state and inputs (same-cycle); state and counters are registered.
- Load-use:
  - Exactly one stall cycle per occurrence.
  - The next cycle's lu is false, because the load has moved to MEM and the bubble is in EX.
- MUL/DIV latency: START in cycle 0 and DONE in cycle k (k≥1) give freeze cycles 0..k-1; the pipeline advances in cycle k.
- Watchdog: with no DONE, the freeze lasts MD_TIMEOUT cycles and release occurs in cycle MD_TIMEOUT.
- Branch flush costs 2 slots (the IF/ID and ID/EX entries) and no stall cycles.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - state encoding constants;
  - NOP_INSTR = 32'h00000013;
  - the register-index width of 5.
- One natural sub-module: load_use_detect, the combinational lu comparator, reused by the forwarding unit.

## Test plan
- RESET=0 for 2 cycles, then 1 → during reset PC_WRITE_EN=0, IF_ID_FLUSH=1, STALL_COUNT=0; after release all enables are 1.
- ID_EX_MEM_READ=1, ID_EX_RD=5, ID_RS2=5, ID_USES_RS2=1 → one cycle with PC_WRITE_EN=0 and ID_EX_BUBBLE=1; STALL_COUNT=1. Repeat with ID_EX_RD=0 → no stall.
- MULDIV_START at cycle 0, MULDIV_DONE at cycle 33 → freeze in cycles 0–32, advance in cycle 33, STALL_COUNT=33, MD_TIMEOUT_ERR=0.
- BRANCH_TAKEN=1 together with lu=1 and MULDIV_START=1 → flush only (IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_WRITE_EN=1); state stays RUN.
- MD_TIMEOUT=40, MULDIV_START with no DONE → release in cycle 40; MD_TIMEOUT_ERR=1 and stays 1.
- RESET=0 in cycle 10 of MD_WAIT → state RUN and md_cnt=0 after reset; no freeze after RESET=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the RV32IM pipeline sequencing controller and the
// units that reuse its pieces (hazard/forwarding logic).
//   state_t      : controller states (1-bit encoding)
//   ctrl_t       : bundle of pipeline-register control strobes
//   NOP_INSTR    : instruction word loaded into IF/ID on a flush
//   REG_IDX_W    : architectural register index width
//   ctrl_*()     : canonical control patterns used by the controller
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pcWriteEn;
    logic ifIdWriteEn;
    logic ifIdFlush;
    logic idExWriteEn;
    logic idExBubble;
    logic exMemBubble;
  } ctrl_t;

  // Normal advance: every stage captures, nothing is squashed.
  function automatic ctrl_t ctrl_advance();
    ctrl_t c;
    c.pcWriteEn   = 1'b1;
    c.ifIdWriteEn = 1'b1;
    c.ifIdFlush   = 1'b0;
    c.idExWriteEn = 1'b1;
    c.idExBubble  = 1'b0;
    c.exMemBubble = 1'b0;
    return c;
  endfunction

  // Held in reset: nothing advances and every stage is squashed.
  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c.pcWriteEn   = 1'b0;
    c.ifIdWriteEn = 1'b0;
    c.ifIdFlush   = 1'b1;
    c.idExWriteEn = 1'b0;
    c.idExBubble  = 1'b1;
    c.exMemBubble = 1'b1;
    return c;
  endfunction

  // Taken branch/jump: squash the two younger wrong-path entries while the
  // PC moves on to the target.
  function automatic ctrl_t ctrl_flush();
    ctrl_t c;
    c = ctrl_advance();
    c.ifIdFlush  = 1'b1;
    c.idExBubble = 1'b1;
    return c;
  endfunction

  // MUL/DIV busy: the whole front end holds, and MEM receives bubbles while
  // EX keeps the multi-cycle operation.
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c = ctrl_advance();
    c.pcWriteEn   = 1'b0;
    c.ifIdWriteEn = 1'b0;
    c.idExWriteEn = 1'b0;
    c.exMemBubble = 1'b1;
    return c;
  endfunction

  // Load-use: hold PC and IF/ID for one cycle and push a bubble into EX so
  // the load can reach MEM before the consumer reads its result.
  function automatic ctrl_t ctrl_load_use();
    ctrl_t c;
    c = ctrl_advance();
    c.pcWriteEn   = 1'b0;
    c.ifIdWriteEn = 1'b0;
    c.idExBubble  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the pipeline datapath and the sequencing controller.
//   Load-use inputs : ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
//                     ID_EX_MEM_READ, ID_EX_RD
//   EX events       : BRANCH_TAKEN, MULDIV_START, MULDIV_DONE
//   Controls        : PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH,
//                     ID_EX_WRITE_EN, ID_EX_BUBBLE, EX_MEM_BUBBLE
//   Status          : STALL_COUNT, MD_TIMEOUT_ERR
// master = datapath side, slave = controller side.
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] ID_RS1;
  logic [REG_IDX_W-1:0] ID_RS2;
  logic                 ID_USES_RS1;
  logic                 ID_USES_RS2;
  logic                 ID_EX_MEM_READ;
  logic [REG_IDX_W-1:0] ID_EX_RD;

  logic                 BRANCH_TAKEN;
  logic                 MULDIV_START;
  logic                 MULDIV_DONE;

  logic                 PC_WRITE_EN;
  logic                 IF_ID_WRITE_EN;
  logic                 IF_ID_FLUSH;
  logic                 ID_EX_WRITE_EN;
  logic                 ID_EX_BUBBLE;
  logic                 EX_MEM_BUBBLE;

  logic [31:0]          STALL_COUNT;
  logic                 MD_TIMEOUT_ERR;

  modport master (
    output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, ID_EX_MEM_READ, ID_EX_RD,
    output BRANCH_TAKEN, MULDIV_START, MULDIV_DONE,
    input  PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH,
    input  ID_EX_WRITE_EN, ID_EX_BUBBLE, EX_MEM_BUBBLE,
    input  STALL_COUNT, MD_TIMEOUT_ERR
  );

  modport slave (
    input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, ID_EX_MEM_READ, ID_EX_RD,
    input  BRANCH_TAKEN, MULDIV_START, MULDIV_DONE,
    output PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH,
    output ID_EX_WRITE_EN, ID_EX_BUBBLE, EX_MEM_BUBBLE,
    output STALL_COUNT, MD_TIMEOUT_ERR
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. x0 is never a real dependency.
//   i_idRs1, i_idRs2         : source indices of the ID instruction
//   i_idUsesRs1, i_idUsesRs2 : which sources the ID instruction really reads
//   i_exMemRead              : EX instruction is a load
//   i_exRd                   : destination index of the EX instruction
//   o_loadUse                : dependency that forwarding cannot cover
// ---------------------------------------------------------------------------
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] i_idRs1,
  input  logic [REG_IDX_W-1:0] i_idRs2,
  input  logic                 i_idUsesRs1,
  input  logic                 i_idUsesRs2,
  input  logic                 i_exMemRead,
  input  logic [REG_IDX_W-1:0] i_exRd,
  output logic                 o_loadUse
);

  logic w_rdValid;
  logic w_hitRs1;
  logic w_hitRs2;

  assign w_rdValid = (i_exRd != '0);
  assign w_hitRs1  = i_idUsesRs1 && (i_idRs1 == i_exRd);
  assign w_hitRs2  = i_idUsesRs2 && (i_idRs2 == i_exRd);
  assign o_loadUse = i_exMemRead && w_rdValid && (w_hitRs1 || w_hitRs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Sequencing controller for the RV32IM pipeline. Drives write-enable, flush
// and bubble strobes of PC, IF/ID, ID/EX and EX/MEM to resolve load-use
// stalls, taken-branch flushes and multi-cycle MUL/DIV freezes (with a
// watchdog that forces release after MD_TIMEOUT wait cycles).
//   CLK     : clock, all state updates on posedge
//   RESET   : synchronous active-low reset
//   bus     : pipeline_hazard_ctrl_if.slave (detection inputs, EX events,
//             control strobes, STALL_COUNT and MD_TIMEOUT_ERR status)
// Control strobes are combinational (Mealy); state and counters registered.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40
) (
  input logic                   CLK,
  input logic                   RESET,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_mdCnt;
  logic [31:0]      r_stallCount;
  logic             r_mdErr;

  state_t           w_nextState;
  logic [CNT_W-1:0] w_nextMdCnt;
  logic             w_setErr;
  logic             w_loadUse;
  ctrl_t            w_ctrl;

  load_use_detect u_loadUse (
    .i_idRs1     (bus.ID_RS1),
    .i_idRs2     (bus.ID_RS2),
    .i_idUsesRs1 (bus.ID_USES_RS1),
    .i_idUsesRs2 (bus.ID_USES_RS2),
    .i_exMemRead (bus.ID_EX_MEM_READ),
    .i_exRd      (bus.ID_EX_RD),
    .o_loadUse   (w_loadUse)
  );

  // State, wait counter and status registers. Reset abandons any MUL/DIV
  // wait in progress; the error flag is sticky until the next reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state      <= ST_RUN;
      r_mdCnt      <= '0;
      r_stallCount <= '0;
      r_mdErr      <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_mdCnt <= w_nextMdCnt;
      if (w_setErr) begin
        r_mdErr <= 1'b1;
      end
      if (!w_ctrl.pcWriteEn && (r_stallCount != 32'hFFFF_FFFF)) begin
        r_stallCount <= r_stallCount + 32'd1;
      end
    end
  end

  // Next-state and control strobes. In RUN a taken branch outranks a
  // MUL/DIV start, which outranks a load-use stall. In MD_WAIT, EX is
  // occupied by the MUL/DIV, so branch and load-use inputs are irrelevant;
  // the counter equals the index of the current wait cycle, so release on
  // timeout lands exactly MD_TIMEOUT cycles after the start.
  always_comb begin
    w_nextState = r_state;
    w_nextMdCnt = r_mdCnt;
    w_setErr    = 1'b0;
    w_ctrl      = ctrl_advance();

    if (!RESET) begin
      w_ctrl      = ctrl_reset();
      w_nextState = ST_RUN;
      w_nextMdCnt = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.BRANCH_TAKEN) begin
            w_ctrl = ctrl_flush();
          end else if (bus.MULDIV_START) begin
            w_ctrl      = ctrl_freeze();
            w_nextState = ST_MD_WAIT;
            w_nextMdCnt = CNT_ONE;
          end else if (w_loadUse) begin
            w_ctrl = ctrl_load_use();
          end
        end
        ST_MD_WAIT: begin
          if (bus.MULDIV_DONE) begin
            w_nextState = ST_RUN;
            w_nextMdCnt = '0;
          end else if (r_mdCnt == CNT_MAX) begin
            w_setErr    = 1'b1;
            w_nextState = ST_RUN;
            w_nextMdCnt = '0;
          end else begin
            w_ctrl      = ctrl_freeze();
            w_nextMdCnt = r_mdCnt + CNT_ONE;
          end
        end
        default: begin
          w_nextState = ST_RUN;
          w_nextMdCnt = '0;
        end
      endcase
    end
  end

  assign bus.PC_WRITE_EN    = w_ctrl.pcWriteEn;
  assign bus.IF_ID_WRITE_EN = w_ctrl.ifIdWriteEn;
  assign bus.IF_ID_FLUSH    = w_ctrl.ifIdFlush;
  assign bus.ID_EX_WRITE_EN = w_ctrl.idExWriteEn;
  assign bus.ID_EX_BUBBLE   = w_ctrl.idExBubble;
  assign bus.EX_MEM_BUBBLE  = w_ctrl.exMemBubble;
  assign bus.STALL_COUNT    = r_stallCount;
  assign bus.MD_TIMEOUT_ERR = r_mdErr;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Scoreboard bench for pipeline_hazard_ctrl. Each stimulus cycle computes the
// expected strobes and status from a cycle-level reference model and queues
// them; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int MD_TIMEOUT = 40;

  typedef struct {
    bit          pc;
    bit          ifWe;
    bit          flush;
    bit          idWe;
    bit          idBub;
    bit          exBub;
    bit          statusKnown;
    logic [31:0] stall;
    bit          err;
  } exp_t;

  logic CLK;
  logic RESET;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  exp_t expQ[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Reference model: whether a MUL/DIV is outstanding and how many cycles
  // have elapsed since it started, plus the observable status values.
  bit          mBusy = 0;
  int          mAge = 0;
  logic [31:0] mStall = '0;
  bit          mErr = 0;
  bit          mKnown = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: actual=%0h expected=%0h", name, $time,
               act, exp);
    end
  endtask

  // One pipeline cycle: drive inputs after the edge, predict this cycle's
  // response and advance the model to the next cycle.
  task automatic applyStimulus(input bit rst, input logic [4:0] rs1,
                               input logic [4:0] rs2, input bit u1,
                               input bit u2, input bit memRd,
                               input logic [4:0] rd, input bit br,
                               input bit mdStart, input bit mdDone);
    exp_t e;
    bit   lu;
    @(posedge CLK);
    #1;
    RESET              = rst;
    bus.ID_RS1         = rs1;
    bus.ID_RS2         = rs2;
    bus.ID_USES_RS1    = u1;
    bus.ID_USES_RS2    = u2;
    bus.ID_EX_MEM_READ = memRd;
    bus.ID_EX_RD       = rd;
    bus.BRANCH_TAKEN   = br;
    bus.MULDIV_START   = mdStart;
    bus.MULDIV_DONE    = mdDone;

    e.statusKnown = mKnown;
    e.stall       = mStall;
    e.err         = mErr;
    {e.pc, e.ifWe, e.flush, e.idWe, e.idBub, e.exBub} = 6'b110100;

    lu = memRd && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));

    if (!rst) begin
      {e.pc, e.ifWe, e.flush, e.idWe, e.idBub, e.exBub} = 6'b001011;
      mBusy  = 0;
      mAge   = 0;
      mStall = '0;
      mErr   = 0;
      mKnown = 1;
    end else if (mBusy) begin
      if (mdDone) begin
        mBusy = 0;
      end else if (mAge >= MD_TIMEOUT) begin
        mBusy = 0;
        mErr  = 1;
      end else begin
        {e.pc, e.ifWe, e.flush, e.idWe, e.idBub, e.exBub} = 6'b000001;
        mAge++;
      end
    end else if (br) begin
      e.flush = 1;
      e.idBub = 1;
    end else if (mdStart) begin
      {e.pc, e.ifWe, e.flush, e.idWe, e.idBub, e.exBub} = 6'b000001;
      mBusy = 1;
      mAge  = 1;
    end else if (lu) begin
      {e.pc, e.ifWe, e.flush, e.idWe, e.idBub, e.exBub} = 6'b000110;
    end

    if (rst && !e.pc && mStall != 32'hFFFF_FFFF) mStall = mStall + 1;
    expQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares the DUT against the oldest queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("PC_WRITE_EN", 32'(bus.PC_WRITE_EN), 32'(e.pc));
        checkOutput("IF_ID_WRITE_EN", 32'(bus.IF_ID_WRITE_EN), 32'(e.ifWe));
        checkOutput("IF_ID_FLUSH", 32'(bus.IF_ID_FLUSH), 32'(e.flush));
        checkOutput("ID_EX_WRITE_EN", 32'(bus.ID_EX_WRITE_EN), 32'(e.idWe));
        checkOutput("ID_EX_BUBBLE", 32'(bus.ID_EX_BUBBLE), 32'(e.idBub));
        checkOutput("EX_MEM_BUBBLE", 32'(bus.EX_MEM_BUBBLE), 32'(e.exBub));
        if (e.statusKnown) begin
          checkOutput("STALL_COUNT", bus.STALL_COUNT, e.stall);
          checkOutput("MD_TIMEOUT_ERR", 32'(bus.MD_TIMEOUT_ERR), 32'(e.err));
        end
      end
    end
  end

  initial begin
    RESET              = 1'b0;
    bus.ID_RS1         = '0;
    bus.ID_RS2         = '0;
    bus.ID_USES_RS1    = 1'b0;
    bus.ID_USES_RS2    = 1'b0;
    bus.ID_EX_MEM_READ = 1'b0;
    bus.ID_EX_RD       = '0;
    bus.BRANCH_TAKEN   = 1'b0;
    bus.MULDIV_START   = 1'b0;
    bus.MULDIV_DONE    = 1'b0;

    // Reset for two cycles, then release.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Load-use on rs2, then the same pattern with rd = x0.
    applyStimulus(1, 0, 5, 0, 1, 1, 5, 0, 0, 0);
    idle(1);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(1);

    // MUL/DIV finishing in cycle 33.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(32);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Branch outranks both load-use and MUL/DIV start.
    applyStimulus(1, 7, 7, 1, 1, 1, 7, 1, 1, 0);
    idle(2);

    // MUL/DIV with no completion: watchdog release in cycle MD_TIMEOUT.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(MD_TIMEOUT + 3);

    // Reset in wait cycle 10; no freeze afterwards.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(9);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Randomized traffic; small register range makes dependencies common.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 79) != 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 29) == 0));
    end

    @(negedge CLK);
    #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d expected=0",
               expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
